// File: rtl/mult_pkg.sv
// Shared types and sizing constants for the sequential Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned ITER          = DEFAULT_WIDTH + 1;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH + 2);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then
// arithmetic right shift of {A,Q,Q_minus_one}.
module booth_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] q,
  input  logic [WIDTH:0] m,
  input  logic           q_m1,
  output logic [WIDTH:0] a_nxt,
  output logic [WIDTH:0] q_nxt,
  output logic           q_m1_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    a_nxt    = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt    = {sum[0], q[WIDTH:1]};
    q_m1_nxt = q[0];
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both
// sides, abort, and a registered product held until the next result.
module booth_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               is_signed,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned STEPS = WIDTH + 1;
  localparam int unsigned CW    = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t         state, state_nxt;
  logic [WIDTH:0] a_r, q_r, m_r;
  logic           qm1_r;
  logic [CW-1:0]  cnt_r;
  logic [WIDTH:0] a_s, q_s;
  logic           qm1_s;
  logic           xfer;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a_r),
    .q        (q_r),
    .m        (m_r),
    .q_m1     (qm1_r),
    .a_nxt    (a_s),
    .q_nxt    (q_s),
    .q_m1_nxt (qm1_s)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        // abort in IDLE only blocks acceptance
        if (in_valid && !abort) begin
          xfer      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort)              state_nxt = IDLE;
        else if (cnt_r == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      q_r     <= '0;
      m_r     <= '0;
      qm1_r   <= 1'b0;
      cnt_r   <= '0;
      product <= '0;
    end else if (xfer) begin
      a_r   <= '0;
      m_r   <= is_signed ? {op_a[WIDTH-1], op_a} : {1'b0, op_a};
      q_r   <= is_signed ? {op_b[WIDTH-1], op_b} : {1'b0, op_b};
      qm1_r <= 1'b0;
      cnt_r <= '0;
    end else if (state == RUN && !abort) begin
      a_r   <= a_s;
      q_r   <= q_s;
      qm1_r <= qm1_s;
      cnt_r <= cnt_r + CW'(1);
      // low 2*WIDTH bits of the (2*WIDTH+2)-bit {A,Q} after the final step
      if (cnt_r == LAST) product <= {a_s[WIDTH-2:0], q_s};
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl against an arithmetic product model.
module tb_booth_seq_ctrl;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, is_signed, abort;
  logic           out_valid, out_ready, busy;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] product;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .is_signed (is_signed),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
    chk("idle_in_ready", in_ready, 1);
    op_a = a; op_b = b; is_signed = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("accept_busy", busy, 1);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp, input bit release_it);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      chk("run_in_ready_low", in_ready, 0);
      tick();
      lat++;
    end
    chk("latency", lat, 33);
    chk(tag, product, exp);
    if (release_it) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("release_in_ready", in_ready, 1);
      chk("release_out_valid", out_valid, 0);
    end
  endtask

  logic [31:0] va [5] = '{32'd3, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] vb [5] = '{32'd5, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
  logic        vs [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [63:0] ve [5] = '{64'h000000000000000F, 64'hFFFFFFFFFFFFFFD6, 64'hFFFFFFFE00000001,
                          64'h0000000000000001, 64'h4000000000000000};

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] held;

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; is_signed = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_product", product, 0);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      start(va[i], vb[i], vs[i]);
      wait_done($sformatf("directed_%0d", i), ve[i], 1'b1);
    end

    // Random vectors checked against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i == 0) rb = 32'd0;
      start(ra, rb, rs);
      wait_done($sformatf("random_%0d", i), ref_prod(ra, rb, rs), 1'b1);
    end

    // Backpressure; in_valid held high to show nothing is accepted
    start(32'h12345678, 32'h9ABCDEF0, 1'b0);
    wait_done("bp_product", ref_prod(32'h12345678, 32'h9ABCDEF0, 1'b0), 1'b0);
    held = product;
    in_valid = 1'b1; op_a = 32'd7; op_b = 32'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product_stable", product, held);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_no_same_edge_accept", busy, 0);
    in_valid = 1'b0;

    // Reset mid-operation
    start(32'hDEADBEEF, 32'h00000003, 1'b1);
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", product, 0);
    chk("midrst_in_ready", in_ready, 1);
    start(32'd2, 32'd2, 1'b0);
    wait_done("after_rst_2x2", 64'd4, 1'b1);

    // Abort in RUN, then abort blocking acceptance in IDLE
    start(32'd100, 32'd200, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    abort = 1'b1;
    tick();
    chk("abort_run_busy", busy, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_idle_no_accept", busy, 0);
    end
    abort = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("abort_no_out_valid", out_valid, 0);
    end

    // Abort in DONE
    start(32'd9, 32'd11, 1'b0);
    wait_done("pre_abort_done", 64'd99, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done_out_valid", out_valid, 0);
    chk("abort_done_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
